// File: rtl/hazard_pkg.sv
// Shared constants for the register-scoreboard stall controller:
// latency-class codes, default latencies and the pending-counter width.
package hazard_pkg;

    localparam int CNT_W = 3;

    localparam logic [1:0] LAT_ALU  = 2'd0;
    localparam logic [1:0] LAT_LOAD = 2'd1;
    localparam logic [1:0] LAT_MUL  = 2'd2;

    localparam int DEF_ALU_LAT  = 2;
    localparam int DEF_LOAD_LAT = 3;
    localparam int DEF_MUL_LAT  = 4;
    localparam int DEF_MUL_OCC  = 2;

endpackage

// File: rtl/sb_down_counter.sv
// Loadable down-counter that stops at zero. A load takes priority over
// the decrement in the same cycle.
module sb_down_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         zero
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (value != '0) begin
            value <= value - 1'b1;
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/scoreboard_ctrl.sv
// Scoreboard stall controller: per-register latency countdowns decide when
// the ID-stage instruction may issue; drives PC hold, IF/ID write and bubble.
module scoreboard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W    = hazard_pkg::CNT_W,
    parameter int ALU_LAT  = DEF_ALU_LAT,
    parameter int LOAD_LAT = DEF_LOAD_LAT,
    parameter int MUL_LAT  = DEF_MUL_LAT,
    parameter int MUL_OCC  = DEF_MUL_OCC
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic [4:0]  id_dest,
    input  logic        id_wr,
    input  logic [1:0]  id_lat,
    input  logic        id_is_mul,
    input  logic        id_flush,
    output logic        pc_stop,
    output logic        ifid_write,
    output logic        ctrl_bubble,
    output logic        issue,
    output logic        pend_any,
    output logic [31:0] stall_count
);

    if (MUL_OCC < 1 || ALU_LAT >= (1 << CNT_W) || LOAD_LAT >= (1 << CNT_W) ||
        MUL_LAT >= (1 << CNT_W) || (MUL_OCC - 1) >= (1 << CNT_W)) begin : g_bad_params
        $error("scoreboard_ctrl: latency parameters do not fit in CNT_W bits");
    end

    logic [CNT_W-1:0] cnt [32];
    logic [31:0]      cnt_zero;
    logic [CNT_W-1:0] lat_sel;
    logic [CNT_W-1:0] mul_cnt_unused;
    logic             mul_zero;
    logic             raw_haz, waw_haz, struct_haz, stall;

    // Register 0 never has a write pending.
    assign cnt[0]      = '0;
    assign cnt_zero[0] = 1'b1;

    for (genvar r = 1; r < 32; r++) begin : g_reg
        sb_down_counter #(.W(CNT_W)) u_cnt (
            .clk      (Clk),
            .rst_n    (Rst_n),
            .load     (issue && id_wr && id_dest == 5'(r)),
            .load_val (lat_sel),
            .value    (cnt[r]),
            .zero     (cnt_zero[r])
        );
    end

    sb_down_counter #(.W(CNT_W)) u_mul_cnt (
        .clk      (Clk),
        .rst_n    (Rst_n),
        .load     (issue && id_is_mul),
        .load_val (CNT_W'(MUL_OCC - 1)),
        .value    (mul_cnt_unused),
        .zero     (mul_zero)
    );

    always_comb begin
        lat_sel = CNT_W'(MUL_LAT);
        case (id_lat)
            LAT_ALU:  lat_sel = CNT_W'(ALU_LAT);
            LAT_LOAD: lat_sel = CNT_W'(LOAD_LAT);
            default:  lat_sel = CNT_W'(MUL_LAT);
        endcase
    end

    // A producer may still issue while an older write to the same dest is in
    // flight, as long as its own result lands strictly after the older one.
    assign raw_haz    = (id_use_rs && id_rs != 5'd0 && !cnt_zero[id_rs]) ||
                        (id_use_rt && id_rt != 5'd0 && !cnt_zero[id_rt]);
    assign waw_haz    = id_wr && id_dest != 5'd0 && cnt[id_dest] >= lat_sel;
    assign struct_haz = id_is_mul && !mul_zero;

    assign stall = id_valid && !id_flush && (raw_haz || waw_haz || struct_haz);

    // id_valid offers the ID instruction; issue=1 accepts it this cycle.
    assign pc_stop     = stall;
    assign ifid_write  = !stall;
    assign ctrl_bubble = stall;
    assign issue       = id_valid && !id_flush && !stall;
    assign pend_any    = !(&cnt_zero);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            stall_count <= '0;
        end else if (stall && stall_count != '1) begin
            stall_count <= stall_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_scoreboard_ctrl.sv
// Directed bench for scoreboard_ctrl: each instruction pushes its expected
// stall run and stall_count into a queue that the issue monitor drains.
module tb_scoreboard_ctrl;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs = '0, id_rt = '0, id_dest = '0;
    logic        id_use_rs = 1'b0, id_use_rt = 1'b0, id_wr = 1'b0;
    logic [1:0]  id_lat = '0;
    logic        id_is_mul = 1'b0, id_flush = 1'b0;
    logic        pc_stop, ifid_write, ctrl_bubble, issue, pend_any;
    logic [31:0] stall_count;

    int total = 0;
    int bad = 0;
    int run = 0;
    logic [39:0] exp_q[$];

    scoreboard_ctrl dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_use_rs   (id_use_rs),
        .id_use_rt   (id_use_rt),
        .id_dest     (id_dest),
        .id_wr       (id_wr),
        .id_lat      (id_lat),
        .id_is_mul   (id_is_mul),
        .id_flush    (id_flush),
        .pc_stop     (pc_stop),
        .ifid_write  (ifid_write),
        .ctrl_bubble (ctrl_bubble),
        .issue       (issue),
        .pend_any    (pend_any),
        .stall_count (stall_count)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue monitor: stall cycles since the last issue and stall_count at issue.
    always @(negedge Clk) begin
        if (!Rst_n || id_flush) begin
            run = 0;
        end else if (issue) begin
            if (exp_q.size() == 0) begin
                check("unexpected_issue", 32'd1, 32'd0);
            end else begin
                logic [39:0] e;
                e = exp_q.pop_front();
                check("stall_cycles", 32'(run), {24'd0, e[39:32]});
                check("stall_count", stall_count, e[31:0]);
            end
            run = 0;
        end else if (pc_stop) begin
            run++;
        end
    end

    // Present one instruction and hold it until issue (bounded). Returns #1
    // after the issuing edge with the inputs still driven.
    task automatic send(input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                        input logic urt, input logic [4:0] dest, input logic wr,
                        input logic [1:0] lat, input logic mul,
                        input int exp_st, input logic [31:0] exp_tot);
        bit done = 0;
        int waited = 0;
        exp_q.push_back({exp_st[7:0], exp_tot});
        id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt;
        id_dest = dest; id_wr = wr; id_lat = lat; id_is_mul = mul;
        id_valid = 1'b1;
        while (!done && waited < 64) begin
            @(negedge Clk);
            if (issue) done = 1;
            waited++;
            @(posedge Clk);
            #1;
        end
        if (!done) begin
            void'(exp_q.pop_back());
            check("issue_timeout", 32'd1, 32'd0);
        end
    endtask

    task automatic idle(input int n);
        id_valid = 1'b0;
        repeat (n) @(posedge Clk);
        #1;
    endtask

    initial begin
        // Reset holds an instruction reading r5; nothing is pending.
        id_valid = 1'b1; id_rs = 5'd5; id_use_rs = 1'b1;
        #3;
        check("rst_pc_stop", {31'd0, pc_stop}, 32'd0);
        check("rst_ifid_write", {31'd0, ifid_write}, 32'd1);
        check("rst_ctrl_bubble", {31'd0, ctrl_bubble}, 32'd0);
        check("rst_issue", {31'd0, issue}, 32'd1);
        check("rst_pend_any", {31'd0, pend_any}, 32'd0);
        check("rst_stall_count", stall_count, 32'd0);
        id_valid = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;

        // ALU producer r8 then reader: 2 stalls.
        send(5'd0, 0, 5'd0, 0, 5'd8, 1, 2'd0, 0, 0, 32'd0);
        send(5'd8, 1, 5'd0, 0, 5'd0, 0, 2'd0, 0, 2, 32'd2);
        idle(4);
        check("pend_idle", {31'd0, pend_any}, 32'd0);

        // Load r9 then rt reader: 3 stalls.
        send(5'd0, 0, 5'd0, 0, 5'd9, 1, 2'd1, 0, 0, 32'd2);
        send(5'd0, 0, 5'd9, 1, 5'd0, 0, 2'd0, 0, 3, 32'd5);
        idle(4);

        // Write to $0 then read $0: no stall.
        send(5'd0, 0, 5'd0, 0, 5'd0, 1, 2'd1, 0, 0, 32'd5);
        send(5'd0, 1, 5'd0, 1, 5'd0, 0, 2'd0, 0, 0, 32'd5);
        idle(4);

        // Mul r10 (cnt 4) then ALU write r10: WAW stalls at 4,3,2.
        send(5'd0, 0, 5'd0, 0, 5'd10, 1, 2'd2, 1, 0, 32'd5);
        send(5'd0, 0, 5'd0, 0, 5'd10, 1, 2'd0, 0, 3, 32'd8);
        idle(5);

        // Back-to-back independent muls: second waits 1 cycle.
        send(5'd0, 0, 5'd0, 0, 5'd11, 1, 2'd2, 1, 0, 32'd8);
        send(5'd0, 0, 5'd0, 0, 5'd12, 1, 2'd3, 1, 1, 32'd9);
        idle(6);

        // rs==rt single check, then dest==rs reload, then reader of reloaded reg.
        send(5'd0, 0, 5'd0, 0, 5'd13, 1, 2'd0, 0, 0, 32'd9);
        send(5'd13, 1, 5'd13, 1, 5'd0, 0, 2'd0, 0, 2, 32'd11);
        send(5'd0, 0, 5'd0, 0, 5'd14, 1, 2'd0, 0, 0, 32'd11);
        send(5'd14, 1, 5'd0, 0, 5'd14, 1, 2'd0, 0, 2, 32'd13);
        send(5'd14, 1, 5'd0, 0, 5'd0, 0, 2'd0, 0, 2, 32'd15);
        idle(4);

        // Load r15, reader stalls once, then flush; counters keep running.
        send(5'd0, 0, 5'd0, 0, 5'd15, 1, 2'd1, 0, 0, 32'd15);
        id_rs = 5'd15; id_use_rs = 1'b1; id_wr = 1'b0; id_dest = 5'd0;
        @(negedge Clk);
        check("pre_flush_pc_stop", {31'd0, pc_stop}, 32'd1);
        @(posedge Clk);
        #1;
        id_flush = 1'b1;
        @(negedge Clk);
        check("flush_pc_stop", {31'd0, pc_stop}, 32'd0);
        check("flush_ifid_write", {31'd0, ifid_write}, 32'd1);
        check("flush_ctrl_bubble", {31'd0, ctrl_bubble}, 32'd0);
        check("flush_issue", {31'd0, issue}, 32'd0);
        check("flush_pend_any", {31'd0, pend_any}, 32'd1);
        check("flush_stall_count", stall_count, 32'd16);
        @(posedge Clk);
        #1;
        id_flush = 1'b0;
        send(5'd15, 1, 5'd0, 0, 5'd0, 0, 2'd0, 0, 1, 32'd17);
        idle(4);

        // Reset mid-countdown clears everything at once.
        send(5'd0, 0, 5'd0, 0, 5'd16, 1, 2'd2, 1, 0, 32'd17);
        id_valid = 1'b0;
        #1;
        check("pre_rst_pend_any", {31'd0, pend_any}, 32'd1);
        Rst_n = 1'b0;
        #1;
        check("mid_rst_pend_any", {31'd0, pend_any}, 32'd0);
        check("mid_rst_stall_count", stall_count, 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;
        send(5'd16, 1, 5'd0, 0, 5'd0, 0, 2'd0, 1, 0, 32'd0);
        idle(3);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
